// File: rtl/uriscv_axi_pkg.sv
// Shared types and constants for the uRISC-V data-side AXI bridge.
// Write strobes are mapped to the narrowest AXI size and aligned byte offset.
package uriscv_axi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD_ADDR = 3'd1,
        ST_RD_DATA = 3'd2,
        ST_WR_REQ  = 3'd3,
        ST_WR_RESP = 3'd4
    } state_t;

    localparam logic [2:0] SIZE_BYTE = 3'd0;
    localparam logic [2:0] SIZE_HALF = 3'd1;
    localparam logic [2:0] SIZE_WORD = 3'd2;

    localparam logic [1:0] BURST_INCR = 2'b01;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef struct packed {
        logic [2:0] size;
        logic [1:0] off;
    } wr_shape_t;

    // Irregular strobe patterns fall back to a full-word access.
    function automatic wr_shape_t strb_to_shape(input logic [3:0] strb);
        wr_shape_t s;
        s.size = SIZE_WORD;
        s.off  = 2'b00;
        case (strb)
            4'hF: begin s.size = SIZE_WORD; s.off = 2'b00; end
            4'h3: begin s.size = SIZE_HALF; s.off = 2'b00; end
            4'hC: begin s.size = SIZE_HALF; s.off = 2'b10; end
            4'h1: begin s.size = SIZE_BYTE; s.off = 2'b00; end
            4'h2: begin s.size = SIZE_BYTE; s.off = 2'b01; end
            4'h4: begin s.size = SIZE_BYTE; s.off = 2'b10; end
            4'h8: begin s.size = SIZE_BYTE; s.off = 2'b11; end
            default: begin s.size = SIZE_WORD; s.off = 2'b00; end
        endcase
        return s;
    endfunction

endpackage

// File: rtl/uriscv_axi_dbridge.sv
// Single-outstanding bridge from the uRISC-V data memory port to AXI4.
// All AXI valid/ready outputs come straight from flops.
module uriscv_axi_dbridge
    import uriscv_axi_pkg::*;
#(
    parameter bit WR_ACK_ON_B = 1'b1
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        mem_d_rd_i,
    input  logic [3:0]  mem_d_wr_i,
    input  logic [31:0] mem_d_addr_i,
    input  logic [31:0] mem_d_data_wr_i,
    output logic        mem_d_accept_o,
    output logic        mem_d_ack_o,
    output logic [31:0] mem_d_data_rd_o,
    output logic        mem_d_err_o,

    output logic [31:0] awaddr,
    output logic [3:0]  awlen,
    output logic [2:0]  awsize,
    output logic [1:0]  awburst,
    output logic        awvalid,
    input  logic        awready,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic        wlast,
    output logic        wvalid,
    input  logic        wready,
    input  logic [1:0]  bresp,
    input  logic        bvalid,
    output logic        bready,

    output logic [31:0] araddr,
    output logic [3:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arburst,
    output logic        arvalid,
    input  logic        arready,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rlast,
    input  logic        rvalid,
    output logic        rready
);

    state_t    state;
    wr_shape_t shape;
    logic      aw_done;
    logic      w_done;
    logic      unused;

    assign unused = ^{rlast, mem_d_addr_i[1:0]};

    assign mem_d_accept_o = (state == ST_IDLE) && (mem_d_rd_i || (|mem_d_wr_i));

    assign shape = strb_to_shape(mem_d_wr_i);

    assign awlen   = 4'd0;
    assign arlen   = 4'd0;
    assign awburst = BURST_INCR;
    assign arburst = BURST_INCR;
    assign arsize  = SIZE_WORD;
    assign wlast   = wvalid;

    // A channel counts as done once its valid has dropped or is handshaking now.
    assign aw_done = !awvalid || awready;
    assign w_done  = !wvalid  || wready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= ST_IDLE;
            awvalid         <= 1'b0;
            wvalid          <= 1'b0;
            arvalid         <= 1'b0;
            bready          <= 1'b0;
            rready          <= 1'b0;
            mem_d_ack_o     <= 1'b0;
            mem_d_err_o     <= 1'b0;
            mem_d_data_rd_o <= 32'd0;
        end else begin
            mem_d_ack_o <= 1'b0;
            mem_d_err_o <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (|mem_d_wr_i) begin
                        state   <= ST_WR_REQ;
                        awvalid <= 1'b1;
                        wvalid  <= 1'b1;
                    end else if (mem_d_rd_i) begin
                        state   <= ST_RD_ADDR;
                        arvalid <= 1'b1;
                    end
                end
                ST_RD_ADDR: begin
                    if (arready) begin
                        arvalid <= 1'b0;
                        rready  <= 1'b1;
                        state   <= ST_RD_DATA;
                    end
                end
                ST_RD_DATA: begin
                    if (rvalid) begin
                        rready          <= 1'b0;
                        mem_d_data_rd_o <= rdata;
                        mem_d_ack_o     <= 1'b1;
                        mem_d_err_o     <= (rresp != RESP_OKAY);
                        state           <= ST_IDLE;
                    end
                end
                ST_WR_REQ: begin
                    if (awvalid && awready)
                        awvalid <= 1'b0;
                    if (wvalid && wready)
                        wvalid <= 1'b0;
                    if (aw_done && w_done) begin
                        bready      <= 1'b1;
                        mem_d_ack_o <= !WR_ACK_ON_B;
                        state       <= ST_WR_RESP;
                    end
                end
                ST_WR_RESP: begin
                    if (bvalid) begin
                        bready      <= 1'b0;
                        mem_d_ack_o <= WR_ACK_ON_B;
                        mem_d_err_o <= (bresp != RESP_OKAY);
                        state       <= ST_IDLE;
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    awvalid <= 1'b0;
                    wvalid  <= 1'b0;
                    arvalid <= 1'b0;
                    bready  <= 1'b0;
                    rready  <= 1'b0;
                end
            endcase
        end
    end

    // Request fields are captured only on the accept cycle.
    always_ff @(posedge clk) begin
        if (mem_d_accept_o) begin
            araddr <= {mem_d_addr_i[31:2], 2'b00};
            awaddr <= {mem_d_addr_i[31:2], shape.off};
            awsize <= shape.size;
            wdata  <= mem_d_data_wr_i;
            wstrb  <= mem_d_wr_i;
        end
    end

endmodule

// File: tb/tb_uriscv_axi_dbridge.sv
// Directed bench for uriscv_axi_dbridge; the bench plays the AXI slave with
// fixed per-cycle timing so every expected value is known in advance.
module tb_uriscv_axi_dbridge;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_d_rd_i = 1'b0;
    logic [3:0]  mem_d_wr_i = 4'h0;
    logic [31:0] mem_d_addr_i = '0;
    logic [31:0] mem_d_data_wr_i = '0;
    logic        mem_d_accept_o, mem_d_ack_o, mem_d_err_o;
    logic [31:0] mem_d_data_rd_o;
    logic [31:0] awaddr, wdata, araddr;
    logic [3:0]  awlen, arlen, wstrb;
    logic [2:0]  awsize, arsize;
    logic [1:0]  awburst, arburst;
    logic        awvalid, wvalid, wlast, bready, arvalid, rready;
    logic        awready = 1'b0, wready = 1'b0, bvalid = 1'b0;
    logic        arready = 1'b0, rvalid = 1'b0, rlast = 1'b1;
    logic [1:0]  bresp = 2'b00, rresp = 2'b00;
    logic [31:0] rdata = '0;

    int n_chk  = 0;
    int n_fail = 0;

    uriscv_axi_dbridge #(.WR_ACK_ON_B(1'b1)) dut (
        .clk(clk), .rst(rst),
        .mem_d_rd_i(mem_d_rd_i), .mem_d_wr_i(mem_d_wr_i), .mem_d_addr_i(mem_d_addr_i),
        .mem_d_data_wr_i(mem_d_data_wr_i), .mem_d_accept_o(mem_d_accept_o),
        .mem_d_ack_o(mem_d_ack_o), .mem_d_data_rd_o(mem_d_data_rd_o), .mem_d_err_o(mem_d_err_o),
        .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awvalid(awvalid), .awready(awready), .wdata(wdata), .wstrb(wstrb),
        .wlast(wlast), .wvalid(wvalid), .wready(wready), .bresp(bresp),
        .bvalid(bvalid), .bready(bready),
        .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arvalid(arvalid), .arready(arready), .rdata(rdata), .rresp(rresp),
        .rlast(rlast), .rvalid(rvalid), .rready(rready)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd_txn(input string tag, input logic [31:0] a, input logic [31:0] d,
                          input logic [1:0] resp, input int ar_wait);
        mem_d_rd_i   = 1'b1;
        mem_d_addr_i = a;
        #1;
        chk({tag, ".accept"}, mem_d_accept_o, 1);
        tick();
        mem_d_rd_i = 1'b0;
        chk({tag, ".arvalid"}, arvalid, 1);
        chk({tag, ".araddr"}, araddr, {a[31:2], 2'b00});
        chk({tag, ".arsize"}, arsize, 2);
        chk({tag, ".arlen"}, arlen, 0);
        chk({tag, ".arburst"}, arburst, 1);
        repeat (ar_wait) tick();
        chk({tag, ".arvalid_hold"}, arvalid, 1);
        arready = 1'b1;
        tick();
        arready = 1'b0;
        chk({tag, ".arvalid_drop"}, arvalid, 0);
        chk({tag, ".rready"}, rready, 1);
        chk({tag, ".ack_early"}, mem_d_ack_o, 0);
        rvalid = 1'b1;
        rdata  = d;
        rresp  = resp;
        tick();
        rvalid = 1'b0;
        chk({tag, ".ack"}, mem_d_ack_o, 1);
        chk({tag, ".data_rd"}, mem_d_data_rd_o, d);
        chk({tag, ".err"}, mem_d_err_o, (resp != 2'b00) ? 1 : 0);
        chk({tag, ".rready_drop"}, rready, 0);
        tick();
        chk({tag, ".ack_pulse"}, mem_d_ack_o, 0);
        chk({tag, ".err_pulse"}, mem_d_err_o, 0);
    endtask

    task automatic wr_txn(input string tag, input logic [31:0] a, input logic [3:0] strb,
                          input logic [31:0] d, input logic [31:0] exp_awaddr,
                          input logic [2:0] exp_size, input int awcyc, input int wcyc,
                          input logic [1:0] resp);
        int last;
        last = (awcyc > wcyc) ? awcyc : wcyc;
        mem_d_wr_i      = strb;
        mem_d_addr_i    = a;
        mem_d_data_wr_i = d;
        #1;
        chk({tag, ".accept"}, mem_d_accept_o, 1);
        tick();
        mem_d_wr_i = 4'h0;
        chk({tag, ".awvalid"}, awvalid, 1);
        chk({tag, ".wvalid"}, wvalid, 1);
        chk({tag, ".awaddr"}, awaddr, exp_awaddr);
        chk({tag, ".awsize"}, awsize, exp_size);
        chk({tag, ".wstrb"}, wstrb, strb);
        chk({tag, ".wdata"}, wdata, d);
        chk({tag, ".wlast"}, wlast, 1);
        for (int c = 0; c <= last; c++) begin
            awready = (c == awcyc);
            wready  = (c == wcyc);
            tick();
            chk({tag, ".awvalid_seq"}, awvalid, (c < awcyc) ? 1 : 0);
            chk({tag, ".wvalid_seq"}, wvalid, (c < wcyc) ? 1 : 0);
            chk({tag, ".bready_seq"}, bready, (c == last) ? 1 : 0);
            chk({tag, ".ack_seq"}, mem_d_ack_o, 0);
        end
        awready = 1'b0;
        wready  = 1'b0;
        tick();
        chk({tag, ".bready_hold"}, bready, 1);
        chk({tag, ".ack_before_b"}, mem_d_ack_o, 0);
        bvalid = 1'b1;
        bresp  = resp;
        tick();
        bvalid = 1'b0;
        chk({tag, ".ack"}, mem_d_ack_o, 1);
        chk({tag, ".err"}, mem_d_err_o, (resp != 2'b00) ? 1 : 0);
        chk({tag, ".bready_drop"}, bready, 0);
        tick();
        chk({tag, ".ack_pulse"}, mem_d_ack_o, 0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst.awvalid", awvalid, 0);
        chk("rst.wvalid", wvalid, 0);
        chk("rst.arvalid", arvalid, 0);
        chk("rst.bready", bready, 0);
        chk("rst.rready", rready, 0);
        chk("rst.ack", mem_d_ack_o, 0);
        chk("rst.err", mem_d_err_o, 0);
        chk("rst.data_rd", mem_d_data_rd_o, 0);
        chk("rst.accept", mem_d_accept_o, 0);
        rst = 1'b0;
        tick();
        chk("idle.accept_none", mem_d_accept_o, 0);
        chk("const.awlen", awlen, 0);
        chk("const.awburst", awburst, 1);

        // Basic read, arready two cycles late
        rd_txn("rd104", 32'h0000_0104, 32'h1234_5678, 2'b00, 2);

        // Byte write to lane 2, same-cycle AW/W handshake
        wr_txn("wr_b2", 32'h0000_0201, 4'h4, 32'h00AB_0000, 32'h0000_0202, 3'd0, 0, 0, 2'b00);
        // W accepted three cycles before AW
        wr_txn("wr_wfirst", 32'h0000_0410, 4'hC, 32'hBEEF_0000, 32'h0000_0412, 3'd1, 3, 0, 2'b00);
        // AW accepted before W
        wr_txn("wr_awfirst", 32'h0000_0503, 4'hF, 32'hCAFE_F00D, 32'h0000_0500, 3'd2, 0, 2, 2'b00);
        wr_txn("wr_b3", 32'h0000_0700, 4'h8, 32'h5A00_0000, 32'h0000_0703, 3'd0, 1, 1, 2'b00);
        wr_txn("wr_odd", 32'h0000_0601, 4'h5, 32'h0011_0022, 32'h0000_0600, 3'd2, 0, 0, 2'b00);
        wr_txn("wr_h0", 32'h0000_0802, 4'h3, 32'h0000_1234, 32'h0000_0800, 3'd1, 0, 0, 2'b00);

        // Error responses
        rd_txn("rd_err", 32'h0000_0900, 32'hDEAD_BEEF, 2'b10, 0);
        wr_txn("wr_err", 32'h0000_0A00, 4'hF, 32'h0000_0001, 32'h0000_0A00, 3'd2, 0, 0, 2'b11);

        // Read and write requested together: write goes first
        mem_d_rd_i      = 1'b1;
        mem_d_wr_i      = 4'hF;
        mem_d_addr_i    = 32'h0000_0300;
        mem_d_data_wr_i = 32'h1111_2222;
        #1;
        chk("both.accept", mem_d_accept_o, 1);
        tick();
        mem_d_wr_i = 4'h0;
        chk("both.awvalid", awvalid, 1);
        chk("both.arvalid", arvalid, 0);
        chk("both.accept_busy", mem_d_accept_o, 0);
        awready = 1'b1;
        wready  = 1'b1;
        tick();
        awready = 1'b0;
        wready  = 1'b0;
        chk("both.bready", bready, 1);
        bvalid = 1'b1;
        tick();
        bvalid = 1'b0;
        chk("both.wr_ack", mem_d_ack_o, 1);
        chk("both.rd_accept", mem_d_accept_o, 1);
        tick();
        mem_d_rd_i = 1'b0;
        chk("both.arvalid2", arvalid, 1);
        chk("both.araddr", araddr, 32'h0000_0300);
        chk("both.ack_gap", mem_d_ack_o, 0);
        arready = 1'b1;
        tick();
        arready = 1'b0;
        rvalid = 1'b1;
        rdata  = 32'h3333_4444;
        rresp  = 2'b00;
        tick();
        rvalid = 1'b0;
        chk("both.rd_ack", mem_d_ack_o, 1);
        chk("both.rd_data", mem_d_data_rd_o, 32'h3333_4444);
        tick();

        // Reset while waiting for read data abandons the read
        mem_d_rd_i   = 1'b1;
        mem_d_addr_i = 32'h0000_0B00;
        tick();
        mem_d_rd_i = 1'b0;
        arready = 1'b1;
        tick();
        arready = 1'b0;
        chk("rstmid.rready", rready, 1);
        rst    = 1'b1;
        rvalid = 1'b1;
        rdata  = 32'h9999_9999;
        tick();
        rst    = 1'b0;
        rvalid = 1'b0;
        chk("rstmid.rready0", rready, 0);
        chk("rstmid.arvalid0", arvalid, 0);
        chk("rstmid.awvalid0", awvalid, 0);
        chk("rstmid.wvalid0", wvalid, 0);
        chk("rstmid.ack0", mem_d_ack_o, 0);
        chk("rstmid.data0", mem_d_data_rd_o, 0);
        tick();
        chk("rstmid.ack_late", mem_d_ack_o, 0);
        rd_txn("rd_after_rst", 32'h0000_0C08, 32'hA5A5_5A5A, 2'b00, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
